// File: rtl/ga_pkg.sv
// Shared gate-array definitions: sequencer phase constants, strobe and CPU
// request bundles, and the Johnson phase decode helper.
package ga_pkg;

  localparam logic [3:0] PH_VCAS0      = 4'd2;
  localparam logic [3:0] PH_VCAS1      = 4'd6;
  localparam logic [3:0] PH_CPU_SAMPLE = 4'd9;
  localparam logic [3:0] PH_CPU_CAS    = 4'd10;
  localparam logic [3:0] PH_READY      = 4'd12;
  localparam logic [3:0] PH_FIRST      = 4'd0;

  typedef struct packed {
    logic mem;
    logic wr;
    logic rd;
  } cpu_req_t;

  localparam cpu_req_t REQ_NONE = '{mem: 1'b0, wr: 1'b0, rd: 1'b0};

  typedef struct packed {
    logic phi_n;
    logic cclk;
    logic ras_n;
    logic cas_n;
    logic cpu_n;
    logic mwe_n;
    logic e244_n;
    logic ready;
  } strobes_t;

  localparam strobes_t STROBES_RESET = '{
    phi_n:  1'b1,
    cclk:   1'b0,
    ras_n:  1'b1,
    cas_n:  1'b1,
    cpu_n:  1'b1,
    mwe_n:  1'b1,
    e244_n: 1'b1,
    ready:  1'b0
  };

  // Returns {valid, phase}; phases 0..8 fill ones from bit 0, 9..15 clear them again.
  function automatic logic [4:0] johnson_to_phase(input logic [7:0] s);
    logic [4:0] result;
    logic [7:0] pattern;
    result = 5'b0_0000;
    for (int p = 0; p < 16; p++) begin
      if (p <= 8) begin
        pattern = 8'hFF >> (8 - p);
      end else begin
        pattern = 8'hFF << (p - 8);
      end
      if (s == pattern) begin
        result = {1'b1, 4'(p)};
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/ga_phase_decode.sv
// Combinational Johnson phase decoder: sequencer vector to {valid, phase}.
module ga_phase_decode
  import ga_pkg::*;
(
  input  logic [7:0] s,
  output logic       valid,
  output logic [3:0] phase
);

  logic [4:0] dec_s;

  // Decode the Johnson vector through the shared helper.
  always_comb begin
    dec_s = johnson_to_phase(s);
  end

  assign valid = dec_s[4];
  assign phase = dec_s[3:0];

endmodule

// File: rtl/ram_clock_gen.sv
// DRAM / CPU timing strobe generator: decodes the sequencer phase, latches the
// CPU request of the slot and registers every strobe.
module ram_clock_gen
  import ga_pkg::*;
(
  input  logic       CLK_n,
  input  logic       RESET,
  input  logic [7:0] S,
  input  logic       MREQ_n,
  input  logic       RD_n,
  input  logic       M1_n,
  input  logic       IORQ_n,
  output logic [3:0] PHASE,
  output logic       PHI_n,
  output logic       CCLK,
  output logic       RAS_n,
  output logic       CAS_n,
  output logic       CPU_n,
  output logic       MWE_n,
  output logic       E244_n,
  output logic       READY,
  output logic       SYNC_ERR
);

  logic       dec_valid_s;
  logic [3:0] dec_phase_s;
  cpu_req_t   req_sample_s;
  cpu_req_t   req_nxt_s;
  cpu_req_t   req_r;
  logic       vcas_win_s;
  logic       cpu_cas_win_s;
  logic       e244_win_s;
  strobes_t   strb_s;
  strobes_t   strb_nxt_s;
  strobes_t   strb_r;
  logic [3:0] phase_r;
  logic       sync_err_r;

  ga_phase_decode u_decode (
    .s     (S),
    .valid (dec_valid_s),
    .phase (dec_phase_s)
  );

  // Classify the Z80 bus state; an interrupt acknowledge never opens a memory slot.
  always_comb begin
    req_sample_s     = REQ_NONE;
    req_sample_s.mem = ~MREQ_n & IORQ_n & (M1_n | IORQ_n);
    req_sample_s.wr  = req_sample_s.mem & RD_n;
    req_sample_s.rd  = req_sample_s.mem & ~RD_n;
  end

  // Request latch: cleared at the start of each rotation or on a bad pattern, loaded at the sample phase.
  always_comb begin
    req_nxt_s = req_r;
    if (!dec_valid_s) begin
      req_nxt_s = REQ_NONE;
    end else if (dec_phase_s == PH_FIRST) begin
      req_nxt_s = REQ_NONE;
    end else if (dec_phase_s == PH_CPU_SAMPLE) begin
      req_nxt_s = req_sample_s;
    end else begin
      req_nxt_s = req_r;
    end
  end

  // Timing windows derived from the decoded phase.
  always_comb begin
    vcas_win_s    = (dec_phase_s == PH_VCAS0) || (dec_phase_s == PH_VCAS0 + 4'd1) ||
                    (dec_phase_s == PH_VCAS1) || (dec_phase_s == PH_VCAS1 + 4'd1);
    cpu_cas_win_s = (dec_phase_s == PH_CPU_CAS) || (dec_phase_s == PH_CPU_CAS + 4'd1);
    e244_win_s    = (dec_phase_s >= PH_CPU_CAS) && (dec_phase_s <= PH_CPU_CAS + 4'd3);
  end

  // Strobe schedule for a valid phase; the latch already holds this slot's request.
  always_comb begin
    strb_s        = STROBES_RESET;
    strb_s.phi_n  = dec_phase_s[1];
    strb_s.cclk   = dec_phase_s[3];
    strb_s.ras_n  = (dec_phase_s[1:0] == 2'b00);
    strb_s.cas_n  = ~(vcas_win_s | (cpu_cas_win_s & req_r.mem));
    strb_s.cpu_n  = ~(dec_phase_s[3:2] == 2'b10);
    strb_s.mwe_n  = ~(cpu_cas_win_s & req_r.wr);
    strb_s.e244_n = ~(e244_win_s & req_r.rd);
    strb_s.ready  = (dec_phase_s >= PH_READY);
  end

  // On a bad pattern the memory strobes go idle while the clocks freeze where they are.
  always_comb begin
    strb_nxt_s = strb_s;
    if (dec_valid_s) begin
      strb_nxt_s = strb_s;
    end else begin
      strb_nxt_s       = STROBES_RESET;
      strb_nxt_s.phi_n = strb_r.phi_n;
      strb_nxt_s.cclk  = strb_r.cclk;
    end
  end

  // Output and state registers.
  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      phase_r    <= 4'd0;
      strb_r     <= STROBES_RESET;
      sync_err_r <= 1'b0;
      req_r      <= REQ_NONE;
    end else begin
      req_r  <= req_nxt_s;
      strb_r <= strb_nxt_s;
      if (dec_valid_s) begin
        phase_r <= dec_phase_s;
      end else begin
        sync_err_r <= 1'b1;
      end
    end
  end

  assign PHASE    = phase_r;
  assign PHI_n    = strb_r.phi_n;
  assign CCLK     = strb_r.cclk;
  assign RAS_n    = strb_r.ras_n;
  assign CAS_n    = strb_r.cas_n;
  assign CPU_n    = strb_r.cpu_n;
  assign MWE_n    = strb_r.mwe_n;
  assign E244_n   = strb_r.e244_n;
  assign READY    = strb_r.ready;
  assign SYNC_ERR = sync_err_r;

endmodule

// File: doc/ram_clock_gen.md
# ram_clock_gen

Decodes the 8-bit Johnson phase vector from the sequencer into a 4-bit phase index. From that index it generates the registered, glitch-free DRAM and CPU timing strobes of the gate array: RAS/CAS, address-mux select, write enable, 244 buffer enable, CPU clock, CRTC clock and READY. It sits directly downstream of the sequencer and feeds the RAM array, the Z80 and the CRTC. One 16-cycle phase rotation equals 1 µs at 16 MHz. Each µs it serves two video byte fetches and one CPU memory slot.

## Interface
Parameters: none.
- CLK_n  in  1  16 MHz master clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- S  in  8  sequencer phase vector; 8-bit Johnson code.
- MREQ_n  in  1  Z80 memory request, active low.
- RD_n  in  1  Z80 read, active low.
- M1_n  in  1  Z80 M1, active low.
- IORQ_n  in  1  Z80 I/O request, active low.
- PHASE  out  4  decoded phase index 0..15.
- PHI_n  out  1  4 MHz CPU clock, inverted.
- CCLK  out  1  1 MHz CRTC clock.
- RAS_n  out  1  DRAM row strobe.
- CAS_n  out  1  DRAM column strobe.
- CPU_n  out  1  address mux select; 0 = CPU address, 1 = video address.
- MWE_n  out  1  DRAM write enable.
- E244_n  out  1  CPU read data buffer enable.
- READY  out  1  Z80 WAIT release; 1 = CPU may proceed.
- SYNC_ERR  out  1  sticky flag for an illegal S pattern.

## Operation
- Phase decode:
  - Phase p in 0..8: S[i]=1 for i<p, all other bits 0.
  - Phase p in 9..15: S[i]=0 for i<p-8, all other bits 1.
  - Any other pattern is invalid.
- Strobe schedule, as a function of the decoded phase:
  - PHI_n = phase[1].
  - CCLK = 1 for phases 8..15.
  - RAS_n = 1 only in phases 0, 4, 8 and 12 (precharge).
  - Video CAS: CAS_n = 0 in phases 2-3 and 6-7, unconditionally.
  - CPU slot: CPU_n = 0 in phases 8..11, 1 otherwise.
  - READY = 1 in phases 12..15 only.
- CPU request latch:
  - Sampled when the decoded phase is 9.
  - mem = ~MREQ_n & IORQ_n.
  - wr = mem & RD_n.
  - rd = mem & ~RD_n.
  - The latch clears at phase 0, on RESET, and on an invalid pattern.
- CPU CAS: CAS_n = 0 in phases 10-11 iff mem is latched.
- MWE_n = 0 in phases 10-11 iff wr is latched.
- E244_n = 0 in phases 10..13 iff rd is latched.
- Interrupt acknowledge (M1_n=0 and IORQ_n=0 at phase 9): mem=0, so no CPU CAS, no MWE_n and no E244_n.
- MREQ_n and IORQ_n both low at phase 9: treated as no access.
- Invalid S pattern:
  - SYNC_ERR is set and stays set until RESET.
  - While the pattern is invalid, PHASE holds its last value and all strobes go idle: RAS_n=CAS_n=MWE_n=E244_n=CPU_n=1, READY=0.
  - Normal generation resumes on the first valid pattern.

## Timing
- Reset values: PHASE=0, PHI_n=1, CCLK=0, RAS_n=1, CAS_n=1, CPU_n=1, MWE_n=1, E244_n=1, READY=0, SYNC_ERR=0. The request latch is cleared.
- Every output is a flop. Each output is registered from the S value sampled on the same edge, so S showing phase p at edge t gives the phase-p output values from edge t+1 onward (latency 1 cycle).
- The request latch is loaded at the same edge that registers phase 9, so it controls the phase 10-11 outputs.
- RESET asserted mid-slot: all outputs reach reset values on the next edge. An access in progress is abandoned, with no partial CAS or MWE pulse.
- The sequencer holding S (repeated pattern): outputs hold with no glitch. The latch is unaffected unless the held phase is 0 or 9.

## Structure
- Package ga_pkg holds:
  - 4-bit phase constants (PH_VCAS0=2, PH_VCAS1=6, PH_CPU_SAMPLE=9, PH_CPU_CAS=10, PH_READY=12).
  - Function johnson_to_phase returning {valid, phase[3:0]}.
- One sub-module, ga_phase_decode: combinational S → {valid, phase}, reused by the video counters.
- The top level contains the request latch, the strobe decode and the output registers.

## Test plan
- Reset then a free-running sequencer for 3 µs:
  - PHI_n toggles every 2 clocks and CCLK has a 50% duty cycle at 1 µs.
  - RAS_n is high only at phases 0, 4, 8, 12.
  - CAS_n is low in phases 2-3 and 6-7, and high in 10-11 because no request is present.
- MREQ_n=0 and RD_n=0 held through phase 9: CAS_n low in phases 10-11, E244_n low in 10..13, MWE_n stays 1, READY high in 12..15.
- MREQ_n=0 and RD_n=1 at phase 9: MWE_n and CAS_n both low in exactly phases 10-11, E244_n stays 1.
- M1_n=0, IORQ_n=0 and MREQ_n=1 at phase 9: no CAS in 10-11, E244_n=1, MWE_n=1.
- Inject S=8'b0101_0000 mid-run: SYNC_ERR=1 on the next edge, all strobes idle, PHASE holds. Valid patterns then resume generation while SYNC_ERR stays 1 until RESET.
- Assert RESET at phase 10 during a write: MWE_n=1 and CAS_n=1 on the next edge, all outputs at reset values.
